// File: rtl/shl_seq_a32_if.sv
// -----------------------------------------------------------------------------
// shl_seq_a32_if
//   Request/response bundle for the sequential 32-bit shift-left unit.
//
//   Signals
//     start  request; the unit accepts it only while busy is low
//     A      operand to shift (captured on the accepting edge)
//     B      shift amount; B[4:0] = distance, B[31:5] = overflow detect
//     rot    (only with SHL_ROTATE_EN) 1 = rotate left instead of shift
//     busy   operation in flight
//     done   one-cycle pulse when C carries a fresh result
//     C      result, held until the next completion
//
//   Modports
//     master  requester side: drives start/A/B(/rot), observes busy/done/C
//     slave   shifter side
//
//   Configuration macro: SHL_ROTATE_EN adds the rot request bit.
// -----------------------------------------------------------------------------
interface shl_seq_a32_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
`ifdef SHL_ROTATE_EN
  logic        rot;
`endif
  logic        busy;
  logic        done;
  logic [31:0] C;

`ifdef SHL_ROTATE_EN
  modport master (output start, A, B, rot, input  busy, done, C);
  modport slave  (input  start, A, B, rot, output busy, done, C);
`else
  modport master (output start, A, B, input  busy, done, C);
  modport slave  (input  start, A, B, output busy, done, C);
`endif
endinterface

// File: rtl/shl_seq_a32.sv
// -----------------------------------------------------------------------------
// shl_seq_a32
//   Sequential 32-bit logical shift-left unit. The operand is captured on the
//   accepting edge, then shifted up to STEP bit positions per clock until the
//   remaining distance reaches zero; the following edge publishes the result
//   on C and pulses done for one cycle. Vacated low bits are zero filled and
//   bits pushed past bit 31 are lost. Distances of 32 or more (any of B[31:5]
//   set) give 0.
//
//   Parameters
//     STEP   bit positions shifted per clock; one of 1, 2, 4, 8, 16
//
//   Ports
//     clk    system clock, rising edge
//     rst    asynchronous active-high reset
//     bus    shl_seq_a32_if.slave (start, A, B[, rot], busy, done, C)
//
//   Configuration macro
//     SHL_ROTATE_EN  adds bus.rot; rot=1 rotates left by B[4:0] (B[31:5]
//                    ignored), same latency. Without it only shifts exist.
//
//   Latency: start accepted at edge k -> done high after edge
//   k + 1 + ceil(n / STEP), n = effective distance (0 on overflow).
// -----------------------------------------------------------------------------
module shl_seq_a32 #(
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  shl_seq_a32_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // STEP never exceeds 16, so the per-cycle amount fits the 5-bit counter.
  localparam logic [4:0] STEP_W = 5'(STEP);

  logic [0:0]  state_reg;
  logic [31:0] r_reg;      // working shift register
  logic [4:0]  n_reg;      // remaining distance
  logic [31:0] c_reg;      // published result
  logic        busy_reg;
  logic        done_reg;

  logic        rot_req;    // rotate requested on the current start
  logic        rot_mode;   // rotate mode of the operation in flight
  logic        clear_op;   // overflowing shift: result forced to zero
  logic [4:0]  amt;        // positions to move this cycle
  logic [31:0] stage [0:5];

`ifdef SHL_ROTATE_EN
  logic rot_reg;
  assign rot_req  = bus.rot;
  assign rot_mode = rot_reg;
`else
  assign rot_req  = 1'b0;
  assign rot_mode = 1'b0;
`endif

  // Rotation is modulo 32, so the overflow bits only matter for plain shifts.
  assign clear_op = (|bus.B[31:5]) & ~rot_req;

  // min(N, STEP) on 5 bits: the last cycle moves only what is left.
  assign amt = (n_reg < STEP_W) ? n_reg : STEP_W;

  // Five-stage logarithmic shifter driven by amt. Stage gi moves by 2**gi
  // when bit gi of amt is set; in rotate mode the bits leaving the top are
  // fed back in at the bottom instead of zeros.
  assign stage[0] = r_reg;
  for (genvar gi = 0; gi < 5; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    logic [31:0] moved;
    assign moved = rot_mode ? {stage[gi][31-SH:0], stage[gi][31:32-SH]}
                            : {stage[gi][31-SH:0], {SH{1'b0}}};
    assign stage[gi+1] = amt[gi] ? moved : stage[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      n_reg     <= '0;
      c_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SHL_ROTATE_EN
      rot_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // done is a single-cycle pulse; it also drops when a back-to-back
          // request is accepted in the done cycle.
          done_reg <= 1'b0;
          if (bus.start) begin
            r_reg     <= clear_op ? '0 : bus.A;
            n_reg     <= clear_op ? '0 : bus.B[4:0];
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
`ifdef SHL_ROTATE_EN
            rot_reg   <= rot_req;
`endif
          end
        end
        SHIFT: begin
          if (n_reg != 5'd0) begin
            r_reg <= stage[5];
            n_reg <= n_reg - amt;
          end else begin
            c_reg     <= r_reg;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.C    = c_reg;

endmodule
